tick_gen: RTL and testbench

//  Upstream stage of the timer datapath: turns the free-running system clock into single-cycle

---
 rtl/tick_gen.sv | 86 ++++++++
 tb/tb_tick_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Prescaled tick generator with start/stop toggle and clear for the timer datapath.
// Button is synchronized and edge-detected; ticks pulse once per CLK_DIV cycles in RUN.
module tick_gen #(
  parameter  int CLK_DIV = 100_000,
  localparam int DIV_W   = (CLK_DIV == 1) ? 1 : $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_stop,
  input  logic             clear,
  output logic             tick,
  output logic             clear_out,
  output logic             running,
  output logic [DIV_W-1:0] div_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             s1, s2, s3;
  logic             press;

  // Loading ones on reset keeps a button held through reset from reading as a press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= start_stop;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s2 & ~s3;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_count;
    if (clear) begin
      state_nxt = IDLE;
      div_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          div_nxt = '0;
          if (press) state_nxt = RUN;
        end
        // The prescaler advances in the cycle of a pause press, so a terminal
        // cycle still wraps to zero as the block drops into PAUSE.
        RUN: begin
          div_nxt = (div_count == DIV_MAX) ? '0 : div_count + DIV_W'(1);
          if (press) state_nxt = PAUSE;
        end
        PAUSE: begin
          if (press) state_nxt = RUN;
        end
        default: begin
          state_nxt = IDLE;
          div_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_count <= '0;
      tick      <= 1'b0;
      clear_out <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_count <= div_nxt;
      tick      <= (state == RUN) && (div_count == DIV_MAX) && !clear;
      clear_out <= clear;
      running   <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: CLK_DIV=4 and CLK_DIV=1 instances share random stimulus and are
// checked every cycle against a model based on total RUN cycles since the last idle.
module tb_tick_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_stop = 1'b1;
  logic       clear = 1'b0;
  logic       tick4, clr4, run4;
  logic [1:0] div4;
  logic       tick1, clr1, run1;
  logic [0:0] div1;

  tick_gen #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
    .tick(tick4), .clear_out(clr4), .running(run4), .div_count(div4)
  );

  tick_gen #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
    .tick(tick1), .clear_out(clr1), .running(run1), .div_count(div1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0=idle 1=run 2=pause; run_cycles counts RUN cycles since the last
  // idle, so the prescaler is simply run_cycles mod CLK_DIV.
  function automatic int ndiv(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  int       mode[2];
  int       run_cycles[2];
  logic [2:0] hist[2];
  logic     e_tick[2], e_clr[2], e_run[2];
  int       e_div[2];
  bit       armed = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit pr;
      if (!reset_n) begin
        hist[k]       = 3'b111;
        mode[k]       = 0;
        run_cycles[k] = 0;
        e_tick[k]     = 1'b0;
        e_clr[k]      = 1'b0;
      end else begin
        pr        = hist[k][1] && !hist[k][2];
        e_tick[k] = (mode[k] == 1) && (run_cycles[k] % ndiv(k) == ndiv(k) - 1) && !clear;
        e_clr[k]  = clear;
        if (clear) begin
          mode[k]       = 0;
          run_cycles[k] = 0;
        end else begin
          if (mode[k] == 1) run_cycles[k]++;
          if (pr) mode[k] = (mode[k] == 1) ? 2 : 1;
        end
        hist[k] = {hist[k][1:0], start_stop};
      end
      e_run[k] = (mode[k] == 1);
      e_div[k] = run_cycles[k] % ndiv(k);
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("tick4", 32'(tick4), 32'(e_tick[0]));
      chk("clear_out4", 32'(clr4), 32'(e_clr[0]));
      chk("running4", 32'(run4), 32'(e_run[0]));
      chk("div_count4", 32'(div4), 32'(e_div[0]));
      chk("tick1", 32'(tick1), 32'(e_tick[1]));
      chk("clear_out1", 32'(clr1), 32'(e_clr[1]));
      chk("running1", 32'(run1), 32'(e_run[1]));
      chk("div_count1", 32'(div1), 32'(e_div[1]));
    end
  end

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Button held high through reset is not a press.
    repeat (20) begin
      post_edge();
      chk("held_idle_run", 32'(run4), 0);
      chk("held_idle_tick", 32'(tick4), 0);
    end

    // Clean press: RUN two edges after the input is first sampled high.
    @(negedge clk) start_stop = 1'b0;
    repeat (4) @(negedge clk);
    start_stop = 1'b1;
    repeat (2) @(posedge clk);
    post_edge();
    chk("enter_run4", 32'(run4), 1);
    chk("enter_div4", 32'(div4), 0);
    chk("enter_run1", 32'(run1), 1);
    chk("enter_tick1", 32'(tick1), 0);
    post_edge();
    chk("first_tick1", 32'(tick1), 1);
    chk("div4_1", 32'(div4), 1);
    chk("no_tick4_early", 32'(tick4), 0);
    repeat (2) post_edge();
    chk("div4_3", 32'(div4), 3);
    chk("no_tick4_at3", 32'(tick4), 0);
    post_edge();
    chk("first_tick4", 32'(tick4), 1);
    chk("div4_wrap", 32'(div4), 0);
    post_edge();
    chk("tick4_one_wide", 32'(tick4), 0);

    // Clear from RUN.
    @(negedge clk) clear = 1'b1;
    post_edge();
    chk("clr_running", 32'(run4), 0);
    chk("clr_pulse", 32'(clr4), 1);
    chk("clr_div", 32'(div4), 0);
    chk("clr_tick", 32'(tick4), 0);
    @(negedge clk) clear = 1'b0;
    post_edge();
    chk("clr_pulse_end", 32'(clr4), 0);

    // CLK_DIV=1 run, then reset mid-RUN.
    @(negedge clk) start_stop = 1'b0;
    repeat (4) @(negedge clk);
    start_stop = 1'b1;
    repeat (3) post_edge();
    chk("rerun1", 32'(run1), 1);
    post_edge();
    chk("rerun_tick1", 32'(tick1), 1);
    @(negedge clk) reset_n = 1'b0;
    post_edge();
    chk("rst_tick1", 32'(tick1), 0);
    chk("rst_run1", 32'(run1), 0);
    @(negedge clk) reset_n = 1'b1;

    // Random button activity, clears and occasional resets.
    repeat (4000) begin
      @(negedge clk);
      #1;
      if ($urandom_range(7) == 0) start_stop = ~start_stop;
      clear   = ($urandom_range(31) == 0);
      reset_n = ($urandom_range(299) != 0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
